// File: rtl/ft_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// ft_tx_arbiter_if
// Bundles the source-side streams and the TX-FIFO write port of the FT601 TX
// arbiter into one interface.
//   master : arbiter side. Drives src_ready, wr_data, wr_en, grant and busy.
//   slave  : environment side. Drives ft_ready, src_valid, src_data,
//            src_last and wr_full.
// Signals:
//   ft_ready   link up; new grants only while high
//   src_valid  per-source data valid                 [N_SRC]
//   src_data   per-source word, source i at [32*i+31:32*i]
//   src_last   per-source end of packet              [N_SRC]
//   src_ready  per-source accept                     [N_SRC]
//   wr_data    word to TX FIFO                       [32]
//   wr_en      TX FIFO write strobe
//   wr_full    TX FIFO full
//   grant      index of the granted source           [4]
//   busy       a packet (header or data) is in progress
// ---------------------------------------------------------------------------
interface ft_tx_arbiter_if #(
    parameter int N_SRC = 4
);
    logic                   ft_ready;
    logic [N_SRC-1:0]       src_valid;
    logic [32*N_SRC-1:0]    src_data;
    logic [N_SRC-1:0]       src_last;
    logic [N_SRC-1:0]       src_ready;
    logic [31:0]            wr_data;
    logic                   wr_en;
    logic                   wr_full;
    logic [3:0]             grant;
    logic                   busy;

    modport master (
        input  ft_ready, src_valid, src_data, src_last, wr_full,
        output src_ready, wr_data, wr_en, grant, busy
    );

    modport slave (
        output ft_ready, src_valid, src_data, src_last, wr_full,
        input  src_ready, wr_data, wr_en, grant, busy
    );
endinterface

// File: rtl/ft_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ft_tx_arbiter
// Shares the FT601 TX write-FIFO port among N_SRC streaming sources with
// round-robin arbitration. Each grant writes one header word
// {HDR_MAGIC, src_id[3:0], seq[3:0], 8'h00} followed by up to MAX_BURST data
// words passed straight through from the granted source. A packet ends on the
// source's src_last or is force-closed after MAX_BURST data words; the source
// then simply continues in a later packet with a fresh header.
// Ports:
//   wr_clk   in  FIFO write clock, the only clock of the block
//   sys_rst  in  synchronous active-high reset
//   bus      ft_tx_arbiter_if.master (sources + TX FIFO write port)
// ---------------------------------------------------------------------------
module ft_tx_arbiter #(
    parameter int          N_SRC     = 4,
    parameter int          MAX_BURST = 256,
    parameter logic [15:0] HDR_MAGIC = 16'hA55A
) (
    input  logic            wr_clk,
    input  logic            sys_rst,
    ft_tx_arbiter_if.master bus
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      grant_reg, grant_next;
    logic [3:0]      last_grant_reg, last_grant_next;
    logic [BW-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [3:0]      seq_reg [N_SRC];
    logic            seq_inc;

    logic [31:0]     src_word [N_SRC];
    logic            sel_valid;
    logic            sel_last;
    logic [31:0]     sel_data;
    logic [3:0]      sel_seq;

    logic            pick_found;
    logic [3:0]      pick_idx;

    logic [N_SRC-1:0] src_ready_next;
    logic [31:0]     wr_data_next;
    logic            wr_en_next;
    logic            busy_next;

    // Unpack the flat source data bus into one word per source.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src_word
            assign src_word[gi] = bus.src_data[32*gi +: 32];
        end
    endgenerate

    // Fields of the currently granted source.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_seq   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_reg == 4'(i)) begin
                sel_valid = bus.src_valid[i];
                sel_last  = bus.src_last[i];
                sel_data  = src_word[i];
                sel_seq   = seq_reg[i];
            end
        end
    end

    // Round-robin pick: first valid source strictly above last_grant, else
    // the first valid source from 0 upward (the wrap-around part of the scan).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (!pick_found && bus.src_valid[i] && (4'(i) > last_grant_reg)) begin
                pick_found = 1'b1;
                pick_idx   = 4'(i);
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            if (!pick_found && bus.src_valid[i]) begin
                pick_found = 1'b1;
                pick_idx   = 4'(i);
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        seq_inc         = 1'b0;
        src_ready_next  = '0;
        wr_data_next    = '0;
        wr_en_next      = 1'b0;
        busy_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.ft_ready && pick_found) begin
                    grant_next    = pick_idx;
                    beat_cnt_next = '0;
                    state_next    = HDR;
                end
            end

            HDR: begin
                busy_next    = 1'b1;
                wr_data_next = {HDR_MAGIC, grant_reg, sel_seq, 8'h00};
                wr_en_next   = ~bus.wr_full;
                if (!bus.wr_full) begin
                    seq_inc    = 1'b1;
                    state_next = DATA;
                end
            end

            DATA: begin
                busy_next    = 1'b1;
                wr_data_next = sel_data;
                wr_en_next   = sel_valid & ~bus.wr_full;
                for (int i = 0; i < N_SRC; i++) begin
                    if (grant_reg == 4'(i)) begin
                        src_ready_next[i] = ~bus.wr_full;
                    end
                end
                if (wr_en_next) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    // Close on the source's end of packet or at the burst limit.
                    if (sel_last || (beat_cnt_reg == BW'(MAX_BURST - 1))) begin
                        last_grant_next = grant_reg;
                        state_next      = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (sys_rst) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            last_grant_reg <= 4'(N_SRC - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    // Per-source 4-bit sequence numbers, wrapping 15 -> 0.
    always_ff @(posedge wr_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                seq_reg[i] <= '0;
            end
        end else if (seq_inc) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (grant_reg == 4'(i)) begin
                    seq_reg[i] <= seq_reg[i] + 4'd1;
                end
            end
        end
    end

    assign bus.src_ready = src_ready_next;
    assign bus.wr_data   = wr_data_next;
    assign bus.wr_en     = wr_en_next;
    assign bus.busy      = busy_next;
    assign bus.grant     = grant_reg;

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ft_tx_arbiter
// Randomized bench for ft_tx_arbiter (N_SRC=4, MAX_BURST=4). Each source owns a
// pre-generated list of words split into random-length packets. A
// transaction-level reference model follows the packet protocol: idle gap,
// round-robin grant, header with per-source sequence number, data words in
// source order, closing on last or at the burst limit.
// ---------------------------------------------------------------------------
module tb_ft_tx_arbiter;

    localparam int          N     = 4;
    localparam int          MB    = 4;
    localparam int          NW    = 80;
    localparam int          MAXC  = 8000;
    localparam logic [15:0] MAGIC = 16'hA55A;

    logic clk = 1'b0;
    logic sys_rst;
    always #5 clk = ~clk;

    ft_tx_arbiter_if #(.N_SRC(N)) bus ();

    ft_tx_arbiter #(
        .N_SRC    (N),
        .MAX_BURST(MB),
        .HDR_MAGIC(MAGIC)
    ) dut (
        .wr_clk (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source contents
    logic [31:0] words [N][NW];
    bit          lasts [N][NW];
    int          ptr   [N];     // driver position (advanced on handshake)
    int          eptr  [N];     // model position (advanced on expected write)

    // Reference model
    int          m_phase;       // 0 = between packets, 1 = header due, 2 = data
    int          m_src;
    int          m_beats;
    int          m_last;
    logic [3:0]  m_seq [N];

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (last + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_src   = 0;
        m_beats = 0;
        m_last  = N - 1;
        for (int s = 0; s < N; s++) m_seq[s] = 4'd0;
    endtask

    task automatic monitor();
        logic [N-1:0] v;
        logic         full;
        logic [N-1:0] exp_rdy;
        logic         exp_we;
        bit           closing;
        v    = bus.src_valid;
        full = bus.wr_full;
        if (full) check_eq("wen_while_full", 32'(bus.wr_en), 32'd0);
        case (m_phase)
            0: begin
                check_eq("busy_idle", 32'(bus.busy), 32'd0);
                check_eq("wen_idle", 32'(bus.wr_en), 32'd0);
                check_eq("rdy_idle", 32'(bus.src_ready), 32'd0);
                if (bus.ft_ready && (v != '0)) begin
                    m_src   = rr_pick(m_last, v);
                    m_phase = 1;
                end
            end
            1: begin
                check_eq("busy_hdr", 32'(bus.busy), 32'd1);
                check_eq("grant_hdr", 32'(bus.grant), 32'(m_src));
                check_eq("rdy_hdr", 32'(bus.src_ready), 32'd0);
                check_eq("wen_hdr", 32'(bus.wr_en), 32'(!full));
                if (!full) begin
                    check_eq("hdr_word", bus.wr_data, {MAGIC, 4'(m_src), m_seq[m_src], 8'h00});
                    $display("pkt src=%0d seq=%0d t=%0t", m_src, m_seq[m_src], $time);
                    m_seq[m_src] = m_seq[m_src] + 4'd1;
                    m_beats      = 0;
                    m_phase      = 2;
                end
            end
            default: begin
                check_eq("busy_data", 32'(bus.busy), 32'd1);
                check_eq("grant_data", 32'(bus.grant), 32'(m_src));
                exp_rdy = full ? '0 : N'(1 << m_src);
                check_eq("rdy_data", 32'(bus.src_ready), 32'(exp_rdy));
                exp_we = v[m_src] && !full;
                check_eq("wen_data", 32'(bus.wr_en), 32'(exp_we));
                if (exp_we) begin
                    check_eq("data_word", bus.wr_data, words[m_src][eptr[m_src]]);
                    closing = lasts[m_src][eptr[m_src]] || (m_beats + 1 == MB);
                    eptr[m_src]++;
                    m_beats++;
                    if (closing) begin
                        m_last  = m_src;
                        m_phase = 0;
                    end
                end
            end
        endcase
    endtask

    initial begin
        logic [N-1:0] fire;
        bit  post_rst;
        bit  did_pulse;
        bit  do_pulse;
        bit  ft_on;
        bit  drained;
        int  full_hold;
        int  tail;

        // Build the per-source word lists with random packet lengths.
        for (int s = 0; s < N; s++) begin
            int k;
            k = 0;
            while (k < NW) begin
                int len;
                len = $urandom_range(1, 10);
                for (int j = 0; j < len && k < NW; j++) begin
                    words[s][k] = $urandom;
                    lasts[s][k] = (j == len - 1) || (k == NW - 1);
                    k++;
                end
            end
            ptr[s]  = 0;
            eptr[s] = 0;
        end

        sys_rst       = 1'b1;
        bus.ft_ready  = 1'b0;
        bus.src_valid = '0;
        bus.src_data  = '0;
        bus.src_last  = '0;
        bus.wr_full   = 1'b0;
        model_reset();
        post_rst  = 0;
        did_pulse = 0;
        ft_on     = 1;
        full_hold = 0;
        tail      = -1;

        for (int cyc = 0; cyc < MAXC && tail != 0; cyc++) begin
            @(negedge clk);
            fire = bus.src_valid & bus.src_ready;
            if (sys_rst) begin
                model_reset();
                post_rst = 1;
            end else begin
                if (post_rst) begin
                    check_eq("rst_wen", 32'(bus.wr_en), 32'd0);
                    check_eq("rst_wdata", bus.wr_data, 32'd0);
                    check_eq("rst_rdy", 32'(bus.src_ready), 32'd0);
                    check_eq("rst_grant", 32'(bus.grant), 32'd0);
                    check_eq("rst_busy", 32'(bus.busy), 32'd0);
                    post_rst = 0;
                end
                monitor();
            end

            @(posedge clk);
            #1;
            for (int s = 0; s < N; s++) if (fire[s]) ptr[s]++;

            do_pulse = !did_pulse && (cyc >= 600) && (m_phase == 2);
            if (do_pulse) begin
                did_pulse = 1;
                $display("reset pulse mid-packet src=%0d t=%0t", m_src, $time);
            end
            sys_rst = (cyc < 2) || do_pulse;

            if (cyc % 25 == 0) ft_on = ($urandom_range(0, 3) != 0);
            bus.ft_ready = ft_on;

            if (full_hold > 0) begin
                full_hold--;
                bus.wr_full = 1'b1;
            end else if ($urandom_range(0, 40) == 0) begin
                full_hold   = 4;
                bus.wr_full = 1'b1;
            end else begin
                bus.wr_full = ($urandom_range(0, 4) == 0);
            end
            // Keep the reset cycle free of transfers.
            if (do_pulse) bus.wr_full = 1'b1;

            for (int s = 0; s < N; s++) begin
                if (ptr[s] < NW && $urandom_range(0, 3) != 0) begin
                    bus.src_valid[s]        = 1'b1;
                    bus.src_data[32*s +: 32] = words[s][ptr[s]];
                    bus.src_last[s]         = lasts[s][ptr[s]];
                end else begin
                    bus.src_valid[s]        = 1'b0;
                    bus.src_data[32*s +: 32] = $urandom;
                    bus.src_last[s]         = 1'($urandom_range(0, 1));
                end
            end

            drained = did_pulse && (m_phase == 0);
            for (int s = 0; s < N; s++) if (ptr[s] != NW) drained = 0;
            if (drained && tail < 0) tail = 10;
            else if (tail > 0) tail--;
        end

        check_eq("reset_pulse_done", 32'(did_pulse), 32'd1);
        for (int s = 0; s < N; s++) begin
            check_eq("src_drained", 32'(ptr[s]), 32'(NW));
            check_eq("model_consumed", 32'(eptr[s]), 32'(NW));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
